uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter (8-bit din / write strobe / TE status) among N_REQ byte

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin, message-atomic sharing of one UART TX among  |
// | N_REQ byte requesters, write pacing by the transmitter-empty flag.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int BUSY_WAIT = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         uart_din_o,
  output logic               uart_wr_o,
  input  logic               uart_te_i,
  output logic               busy_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  grant_q;
  logic [7:0]        din_q;
  logic              wr_q;
  logic              busy_q;
  logic              lock_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;

  logic [PW-1:0]     rr_sel;
  logic              rr_found;
  logic [PW-1:0]     sel_d;
  logic              go_d;
  logic [N_REQ-1:0]  sel_onehot_d;
  logic [PW-1:0]     ptr_d;

  // Scan requesters starting at the round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    rr_sel   = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!rr_found && req_i[idx]) begin
        rr_found = 1'b1;
        rr_sel   = PW'(idx);
      end
    end
  end

  assign sel_d = lock_q ? owner_q : rr_sel;
  assign go_d  = uart_te_i & (lock_q ? req_i[owner_q] : rr_found);
  assign ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    sel_onehot_d        = '0;
    sel_onehot_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ack_q   <= '0;
      grant_q <= '0;
      din_q   <= 8'h00;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      wr_q  <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (go_d) begin
            din_q   <= req_data_i[8*sel_d +: 8];
            wr_q    <= 1'b1;
            ack_q   <= sel_onehot_d;
            grant_q <= sel_onehot_d;
            owner_q <= sel_d;
            lock_q  <= ~req_last_i[sel_d];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // A transmitter that never drops TE is released after BUSY_WAIT cycles.
          if (!uart_te_i || cnt_q == CW'(BUSY_WAIT - 1)) begin
            state_q <= WAIT_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (uart_te_i) begin
            state_q <= IDLE;
            if (!lock_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_d;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign uart_din_o = din_q;
  assign uart_wr_o  = wr_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: vector table, directed corner cases and randomized     |
// | traffic against an event-level reference model. Revision: 1.0              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int BW = 16;

  logic          clk;
  logic          reset_i;
  logic [NR-1:0] req_i;
  logic [8*NR-1:0] req_data_i;
  logic [NR-1:0] req_last_i;
  logic [NR-1:0] ack_o;
  logic [NR-1:0] grant_o;
  logic [7:0]    uart_din_o;
  logic          uart_wr_o;
  logic          uart_te_i;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N_REQ(NR), .BUSY_WAIT(BW)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .uart_din_o (uart_din_o),
    .uart_wr_o  (uart_wr_o),
    .uart_te_i  (uart_te_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [2:0] last;
    logic       te;
    logic       ewr;
    logic [2:0] eack;
    logic [7:0] edin;
    logic [2:0] egrant;
    logic       ebusy;
  } vec_t;

  vec_t tbl [22];

  // Outputs packed as {wr, ack, din, grant, busy}.
  function automatic int pk(logic wr, logic [2:0] ack, logic [7:0] din, logic [2:0] gr, logic bz);
    return {16'h0, wr, ack, din, gr, bz};
  endfunction

  function automatic int obs();
    return {16'h0, uart_wr_o, ack_o, uart_din_o, grant_o, busy_o};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    req_i      = '0;
    req_data_i = '0;
    req_last_i = '0;
    uart_te_i  = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Random-phase stimulus: per-requester message bytes and the reference model.
  logic [7:0] md [NR][32];
  logic       ml [NR][32];
  int         mcnt [NR];
  int         rd [NR];
  logic       pres [NR];

  int   m_pending, m_k, m_drained, m_open, m_owner, m_ptr, win;
  logic m_wr;
  logic [2:0] m_ack, m_grant;
  logic [7:0] m_din;
  logic m_busy;

  task automatic model_edge();
    m_wr  = 1'b0;
    m_ack = '0;
    win   = -1;
    if (m_pending != 0) begin
      m_k++;
      if (m_drained == 0) begin
        if (!uart_te_i || m_k == BW) m_drained = 1;
      end else if (uart_te_i) begin
        m_pending = 0;
        if (m_open == 0) begin
          m_grant = '0;
          m_busy  = 1'b0;
          m_ptr   = (m_owner + 1) % NR;
        end
      end
    end else if (uart_te_i) begin
      if (m_open != 0) begin
        if (req_i[m_owner]) win = m_owner;
      end else begin
        for (int j = 0; j < NR; j++) begin
          if (win < 0 && req_i[(m_ptr + j) % NR]) win = (m_ptr + j) % NR;
        end
      end
      if (win >= 0) begin
        m_wr      = 1'b1;
        m_ack     = 3'(1 << win);
        m_grant   = 3'(1 << win);
        m_din     = req_data_i[8*win +: 8];
        m_busy    = 1'b1;
        m_open    = req_last_i[win] ? 0 : 1;
        m_owner   = win;
        m_pending = 1;
        m_k       = 0;
        m_drained = 0;
      end
    end
  endtask

  initial begin
    int nw;
    int since;
    int lag;
    int low;
    int total;
    int dut_writes;
    logic [7:0] got [4];
    int edge_at [3];
    int cyc;

    reset_i    = 1'b1;
    req_i      = '0;
    req_data_i = '0;
    req_last_i = '0;
    uart_te_i  = 1'b0;
    tick();
    check("reset_state", obs(), pk(1'b0, 3'b000, 8'h00, 3'b000, 1'b0));

    tbl[0]  = '{3'b001, 8'hA5, 8'h00, 3'b001, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000, 1'b0};
    tbl[1]  = '{3'b001, 8'hA5, 8'h00, 3'b001, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000, 1'b0};
    tbl[2]  = '{3'b001, 8'hA5, 8'h00, 3'b001, 1'b1, 1'b1, 3'b001, 8'hA5, 3'b001, 1'b1};
    tbl[3]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA5, 3'b001, 1'b1};
    tbl[4]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA5, 3'b001, 1'b1};
    tbl[5]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA5, 3'b001, 1'b1};
    tbl[6]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA5, 3'b001, 1'b1};
    tbl[7]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA5, 3'b001, 1'b1};
    tbl[8]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 3'b000, 8'hA5, 3'b000, 1'b0};
    tbl[9]  = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 3'b000, 8'hA5, 3'b000, 1'b0};
    tbl[10] = '{3'b011, 8'h10, 8'hB1, 3'b001, 1'b1, 1'b1, 3'b010, 8'hB1, 3'b010, 1'b1};
    tbl[11] = '{3'b011, 8'h10, 8'hB2, 3'b001, 1'b0, 1'b0, 3'b000, 8'hB1, 3'b010, 1'b1};
    tbl[12] = '{3'b011, 8'h10, 8'hB2, 3'b001, 1'b1, 1'b0, 3'b000, 8'hB1, 3'b010, 1'b1};
    tbl[13] = '{3'b011, 8'h10, 8'hB2, 3'b001, 1'b1, 1'b1, 3'b010, 8'hB2, 3'b010, 1'b1};
    tbl[14] = '{3'b011, 8'h10, 8'hB3, 3'b011, 1'b0, 1'b0, 3'b000, 8'hB2, 3'b010, 1'b1};
    tbl[15] = '{3'b011, 8'h10, 8'hB3, 3'b011, 1'b1, 1'b0, 3'b000, 8'hB2, 3'b010, 1'b1};
    tbl[16] = '{3'b011, 8'h10, 8'hB3, 3'b011, 1'b1, 1'b1, 3'b010, 8'hB3, 3'b010, 1'b1};
    tbl[17] = '{3'b001, 8'h10, 8'h00, 3'b001, 1'b0, 1'b0, 3'b000, 8'hB3, 3'b010, 1'b1};
    tbl[18] = '{3'b001, 8'h10, 8'h00, 3'b001, 1'b1, 1'b0, 3'b000, 8'hB3, 3'b000, 1'b0};
    tbl[19] = '{3'b001, 8'h10, 8'h00, 3'b001, 1'b1, 1'b1, 3'b001, 8'h10, 3'b001, 1'b1};
    tbl[20] = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 8'h10, 3'b001, 1'b1};
    tbl[21] = '{3'b000, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 3'b000, 8'h10, 3'b000, 1'b0};

    // Single-byte message, TE low in idle, then a 3-byte locked message.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      req_i      = tbl[i].req;
      req_data_i = {8'h00, tbl[i].d1, tbl[i].d0};
      req_last_i = tbl[i].last;
      uart_te_i  = tbl[i].te;
      tick();
      check($sformatf("tbl[%0d]", i), obs(),
            pk(tbl[i].ewr, tbl[i].eack, tbl[i].edin, tbl[i].egrant, tbl[i].ebusy));
    end

    // Two single-byte requesters held: writes alternate.
    do_reset();
    req_i      = 3'b011;
    req_data_i = {8'h00, 8'h22, 8'h11};
    req_last_i = 3'b011;
    nw    = 0;
    since = 100;
    for (int c = 0; c < 300 && nw < 4; c++) begin
      since++;
      uart_te_i = (since == 1 || since == 2) ? 1'b0 : 1'b1;
      tick();
      if (uart_wr_o) begin
        got[nw] = uart_din_o;
        nw++;
        since = 0;
      end
    end
    check("alt_count", nw, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nw) check($sformatf("alt_byte%0d", i), int'(got[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // TE stuck high: the busy wait times out and writes are spaced BW+2.
    do_reset();
    req_i      = 3'b001;
    req_data_i = {8'h00, 8'h00, 8'h5A};
    req_last_i = 3'b001;
    uart_te_i  = 1'b1;
    nw  = 0;
    cyc = 0;
    for (int c = 0; c < 300 && nw < 3; c++) begin
      tick();
      cyc++;
      if (uart_wr_o) begin
        edge_at[nw] = cyc;
        nw++;
      end
    end
    check("stuck_count", nw, 3);
    if (nw == 3) begin
      check("stuck_latency", edge_at[0], 1);
      check("stuck_gap0", edge_at[1] - edge_at[0], BW + 2);
      check("stuck_gap1", edge_at[2] - edge_at[1], BW + 2);
    end

    // Reset in WAIT_DONE of a locked message clears lock asynchronously.
    do_reset();
    req_i      = 3'b001;
    req_data_i = {8'h00, 8'h00, 8'hC3};
    req_last_i = 3'b000;
    uart_te_i  = 1'b1;
    tick();
    check("lock_first", obs(), pk(1'b1, 3'b001, 8'hC3, 3'b001, 1'b1));
    req_i     = 3'b000;
    uart_te_i = 1'b0;
    tick();
    tick();
    check("lock_wait", obs(), pk(1'b0, 3'b000, 8'hC3, 3'b001, 1'b1));
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset", obs(), pk(1'b0, 3'b000, 8'h00, 3'b000, 1'b0));
    tick();
    reset_i    = 1'b0;
    req_i      = 3'b010;
    req_data_i = {8'h00, 8'h7E, 8'h00};
    req_last_i = 3'b010;
    uart_te_i  = 1'b1;
    tick();
    check("after_reset", obs(), pk(1'b1, 3'b010, 8'h7E, 3'b010, 1'b1));

    // Randomized traffic against the reference model.
    total = 0;
    for (int r = 0; r < NR; r++) begin
      mcnt[r] = 0;
      rd[r]   = 0;
      pres[r] = 1'b0;
      for (int m = 0; m < 8; m++) begin
        int len;
        len = 1 + int'($urandom % 3);
        for (int b = 0; b < len; b++) begin
          md[r][mcnt[r]] = 8'($urandom);
          ml[r][mcnt[r]] = (b == len - 1);
          mcnt[r]++;
        end
      end
      total += mcnt[r];
    end
    do_reset();
    m_pending = 0; m_k = 0; m_drained = 0; m_open = 0; m_owner = 0; m_ptr = 0;
    m_grant = '0; m_busy = 1'b0; m_din = 8'h00;
    since = 1000; lag = 0; low = 0;
    dut_writes = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pres[r] && rd[r] < mcnt[r] && ($urandom % 4) != 0) pres[r] = 1'b1;
        req_i[r]              = pres[r];
        req_data_i[8*r +: 8]  = pres[r] ? md[r][rd[r]] : 8'h00;
        req_last_i[r]         = pres[r] ? ml[r][rd[r]] : 1'b0;
      end
      since++;
      uart_te_i = (since <= lag) ? 1'b1 : (since <= lag + low) ? 1'b0 : (($urandom % 8) != 0);
      tick();
      model_edge();
      check("rand", obs(), pk(m_wr, m_ack, m_din, m_grant, m_busy));
      if (uart_wr_o) dut_writes++;
      if (win >= 0) begin
        pres[win] = 1'b0;
        rd[win]++;
        since = 0;
        lag   = (($urandom % 6) == 0) ? 20 : int'($urandom % 3);
        low   = 1 + int'($urandom % 4);
      end
    end
    check("rand_all_bytes", dut_writes, total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
